// File: rtl/exe_stage_md.sv
// Execute stage with multi-cycle multiply/divide, sized store lanes and
// forwarding outputs, sitting between ID and MEM on a valid/allow_in handshake.
// The stage holds (ready_go low) while a multiply or divide is still in flight;
// flush kills the resident instruction and aborts the divider.
module exe_stage_md #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        id_to_exe_valid,
    output logic        exe_allow_in,
    output logic        exe_to_mem_valid,
    input  logic        mem_allow_in,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_src1,
    input  logic [31:0] id_src2,
    input  logic [31:0] id_st_data,
    input  logic [11:0] id_alu_op,
    input  logic [2:0]  id_md_op,
    input  logic        id_mem_re,
    input  logic        id_mem_we,
    input  logic [1:0]  id_mem_size,
    input  logic        id_mem_unsigned,
    input  logic        id_gr_we,
    input  logic [4:0]  id_dest,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_result,
    output logic        exe_res_from_mem,
    output logic        exe_gr_we,
    output logic        exe_mem_unsigned,
    output logic        exe_ale,
    output logic [4:0]  exe_dest,
    output logic [1:0]  exe_mem_size,
    output logic [1:0]  exe_addr_low,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dest,
    output logic        fwd_ready,
    output logic [31:0] fwd_data
);

    localparam logic [2:0] MD_NONE    = 3'd0;
    localparam logic [2:0] MD_MUL_W   = 3'd1;
    localparam logic [2:0] MD_MULH_W  = 3'd2;
    localparam logic [2:0] MD_MULH_WU = 3'd3;
    localparam logic [2:0] MD_DIV_W   = 3'd4;
    localparam logic [2:0] MD_DIV_WU  = 3'd6;

    localparam int CNT_W  = 3;
    localparam int ITER_W = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Payload registers
    logic        exe_valid_q;
    logic [31:0] pc_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] st_data_q;
    logic [11:0] alu_op_q;
    logic [2:0]  md_op_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [1:0]  mem_size_q;
    logic        mem_unsigned_q;
    logic        gr_we_q;
    logic [4:0]  dest_q;

    logic        ready_go;
    logic        is_mul;
    logic        is_div;

    // Multiply
    logic [CNT_W-1:0] mul_cnt_q;
    logic             mul_signed;
    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic [63:0]      mul_prod;

    // Divider
    div_state_t        div_state_q;
    logic [ITER_W-1:0] div_cnt_q;
    logic [31:0]       div_rem_q;
    logic [31:0]       div_quo_q;
    logic [31:0]       div_dvs_q;
    logic              div_quo_neg_q;
    logic              div_rem_neg_q;
    logic              div_signed;
    logic              dvd_neg;
    logic              dvs_neg;
    logic [32:0]       rem_shift;
    logic              rem_sub_ok;
    logic [31:0]       rem_d;
    logic [31:0]       quo_d;
    logic [31:0]       div_quo_res;
    logic [31:0]       div_rem_res;

    logic [31:0] alu_result;
    logic [31:0] md_result;
    logic [31:0] mem_addr;
    logic [3:0]  lane_mask;
    logic [31:0] st_wdata;
    logic        is_mem;

    assign is_mul = (md_op_q != MD_NONE) && !md_op_q[2];
    assign is_div = md_op_q[2];

    assign exe_allow_in     = !exe_valid_q || (ready_go && mem_allow_in);
    assign exe_to_mem_valid = exe_valid_q && ready_go && !flush;

    // Valid bit: flush beats everything, otherwise follows ID when we can accept
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_valid_q <= 1'b0;
        end else if (flush) begin
            exe_valid_q <= 1'b0;
        end else if (exe_allow_in) begin
            exe_valid_q <= id_to_exe_valid;
        end
    end

    // Capture the incoming instruction on a successful ID->EXE handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= 32'd0;
            src1_q         <= 32'd0;
            src2_q         <= 32'd0;
            st_data_q      <= 32'd0;
            alu_op_q       <= 12'd0;
            md_op_q        <= MD_NONE;
            mem_re_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_size_q     <= 2'd0;
            mem_unsigned_q <= 1'b0;
            gr_we_q        <= 1'b0;
            dest_q         <= 5'd0;
        end else if (id_to_exe_valid && exe_allow_in) begin
            pc_q           <= id_pc;
            src1_q         <= id_src1;
            src2_q         <= id_src2;
            st_data_q      <= id_st_data;
            alu_op_q       <= id_alu_op;
            md_op_q        <= id_md_op;
            mem_re_q       <= id_mem_re;
            mem_we_q       <= id_mem_we;
            mem_size_q     <= id_mem_size;
            mem_unsigned_q <= id_mem_unsigned;
            gr_we_q        <= id_gr_we;
            dest_q         <= id_dest;
        end
    end

    // One-hot ALU: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui(=src2)
    always_comb begin
        alu_result =
            ({32{alu_op_q[0]}}  & (src1_q + src2_q))                                  |
            ({32{alu_op_q[1]}}  & (src1_q - src2_q))                                  |
            ({32{alu_op_q[2]}}  & {31'd0, ($signed(src1_q) < $signed(src2_q))})       |
            ({32{alu_op_q[3]}}  & {31'd0, (src1_q < src2_q)})                         |
            ({32{alu_op_q[4]}}  & (src1_q & src2_q))                                  |
            ({32{alu_op_q[5]}}  & ~(src1_q | src2_q))                                 |
            ({32{alu_op_q[6]}}  & (src1_q | src2_q))                                  |
            ({32{alu_op_q[7]}}  & (src1_q ^ src2_q))                                  |
            ({32{alu_op_q[8]}}  & (src1_q << src2_q[4:0]))                            |
            ({32{alu_op_q[9]}}  & (src1_q >> src2_q[4:0]))                            |
            ({32{alu_op_q[10]}} & 32'($signed(src1_q) >>> src2_q[4:0]))               |
            ({32{alu_op_q[11]}} & src2_q);
    end

    // Sign-extended operands make a plain 64-bit product correct for both
    // signed and unsigned high halves.
    assign mul_signed = (md_op_q == MD_MULH_W);
    assign mul_a      = {{32{mul_signed & src1_q[31]}}, src1_q};
    assign mul_b      = {{32{mul_signed & src2_q[31]}}, src2_q};
    assign mul_prod   = mul_a * mul_b;

    // Multiply latency counter: restarts whenever the slot can take a new instruction
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mul_cnt_q <= '0;
        end else if (exe_allow_in) begin
            mul_cnt_q <= '0;
        end else if (exe_valid_q && is_mul && (mul_cnt_q != CNT_W'(MUL_LAT - 1))) begin
            mul_cnt_q <= mul_cnt_q + 1'b1;
        end
    end

    // Divider operand magnitudes; mod/div share the same iteration
    assign div_signed = !md_op_q[1];
    assign dvd_neg    = div_signed & src1_q[31];
    assign dvs_neg    = div_signed & src2_q[31];

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_shift  = {div_rem_q, div_quo_q[31]};
        rem_sub_ok = (rem_shift >= {1'b0, div_dvs_q});
        rem_d      = rem_sub_ok ? (rem_shift[31:0] - div_dvs_q) : rem_shift[31:0];
        quo_d      = {div_quo_q[30:0], rem_sub_ok};
    end

    // Divider FSM: IDLE latches operands, RUN iterates, DONE holds until MEM takes it
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            div_state_q   <= DIV_IDLE;
            div_cnt_q     <= '0;
            div_rem_q     <= 32'd0;
            div_quo_q     <= 32'd0;
            div_dvs_q     <= 32'd0;
            div_quo_neg_q <= 1'b0;
            div_rem_neg_q <= 1'b0;
        end else begin
            case (div_state_q)
                DIV_IDLE: begin
                    if (exe_valid_q && is_div) begin
                        div_state_q   <= DIV_RUN;
                        div_cnt_q     <= '0;
                        div_rem_q     <= 32'd0;
                        div_quo_q     <= dvd_neg ? (32'd0 - src1_q) : src1_q;
                        div_dvs_q     <= dvs_neg ? (32'd0 - src2_q) : src2_q;
                        div_quo_neg_q <= dvd_neg ^ dvs_neg;
                        div_rem_neg_q <= dvd_neg;
                    end
                end
                DIV_RUN: begin
                    div_rem_q <= rem_d;
                    div_quo_q <= quo_d;
                    div_cnt_q <= div_cnt_q + 1'b1;
                    if (div_cnt_q == ITER_W'(DIV_ITER - 1)) begin
                        div_state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (exe_valid_q && mem_allow_in) begin
                        div_state_q <= DIV_IDLE;
                    end
                end
                default: div_state_q <= DIV_IDLE;
            endcase
        end
    end

    // Sign fix-up plus the divide-by-zero special case; 0x80000000 / -1 falls
    // out naturally from the magnitude arithmetic.
    always_comb begin
        if (src2_q == 32'd0) begin
            div_quo_res = 32'hFFFF_FFFF;
            div_rem_res = src1_q;
        end else begin
            div_quo_res = div_quo_neg_q ? (32'd0 - div_quo_q) : div_quo_q;
            div_rem_res = div_rem_neg_q ? (32'd0 - div_rem_q) : div_rem_q;
        end
    end

    // Select the multiply/divide result by operation
    always_comb begin
        case (md_op_q)
            MD_MUL_W:               md_result = mul_prod[31:0];
            MD_MULH_W, MD_MULH_WU:  md_result = mul_prod[63:32];
            MD_DIV_W, MD_DIV_WU:    md_result = div_quo_res;
            default:                md_result = div_rem_res;
        endcase
    end

    // Stage completion condition per operation class
    always_comb begin
        if (md_op_q == MD_NONE) begin
            ready_go = 1'b1;
        end else if (is_div) begin
            ready_go = (div_state_q == DIV_DONE);
        end else begin
            ready_go = (mul_cnt_q == CNT_W'(MUL_LAT - 1));
        end
    end

    // Store lane mask and replicated write data by access size
    always_comb begin
        case (mem_size_q)
            2'd0: begin
                lane_mask = 4'b0001 << mem_addr[1:0];
                st_wdata  = {4{st_data_q[7:0]}};
            end
            2'd1: begin
                lane_mask = 4'b0011 << mem_addr[1:0];
                st_wdata  = {2{st_data_q[15:0]}};
            end
            default: begin
                lane_mask = 4'hF;
                st_wdata  = st_data_q;
            end
        endcase
    end

    assign mem_addr = alu_result;
    assign is_mem   = mem_re_q | mem_we_q;
    assign exe_ale  = is_mem & (((mem_size_q == 2'd1) & mem_addr[0]) |
                                ((mem_size_q == 2'd2) & (|mem_addr[1:0])));

    assign exe_result       = (md_op_q == MD_NONE) ? alu_result : md_result;
    assign exe_pc           = pc_q;
    assign exe_res_from_mem = mem_re_q;
    assign exe_gr_we        = gr_we_q;
    assign exe_mem_unsigned = mem_unsigned_q;
    assign exe_dest         = dest_q;
    assign exe_mem_size     = mem_size_q;
    assign exe_addr_low     = mem_addr[1:0];

    // The SRAM is only touched in the cycle MEM accepts, so a stalled store
    // never issues twice.
    assign data_sram_en    = exe_valid_q & ready_go & mem_allow_in & ~flush & is_mem & ~exe_ale;
    assign data_sram_we    = (data_sram_en & mem_we_q) ? lane_mask : 4'h0;
    assign data_sram_addr  = mem_addr;
    assign data_sram_wdata = st_wdata;

    assign fwd_valid = exe_valid_q & gr_we_q & (dest_q != 5'd0);
    assign fwd_dest  = dest_q;
    assign fwd_ready = ready_go & ~mem_re_q;
    assign fwd_data  = exe_result;

endmodule
